// File: rtl/proteus_packer.sv
// rtl/proteus_packer.sv - Proteus write-path packer: align, mask and pack fields into dense words
module proteus_packer #(
  parameter int BIT_WIDTH = 16,
  parameter int BIT_IDX   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cfg_load,
  input  logic [BIT_IDX-1:0]   i_n,
  input  logic [BIT_IDX-1:0]   i_offset,
  input  logic                 i_valid,
  input  logic [BIT_WIDTH-1:0] i_data,
  input  logic                 i_last,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [BIT_WIDTH-1:0] o_data,
  output logic                 o_last,
  input  logic                 i_ready
);

  localparam int CW = $clog2(2 * BIT_WIDTH);
  localparam logic [BIT_IDX-1:0] N_MAX = BIT_IDX'(BIT_WIDTH - 1);
  localparam logic [CW-1:0] WORD_BITS = CW'(BIT_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                   state;
  logic [2*BIT_WIDTH-1:0]   pack_buf;
  logic [CW-1:0]            cnt;
  logic [BIT_IDX-1:0]       cfg_n;
  logic [BIT_IDX-1:0]       cfg_off;

  logic signed [BIT_WIDTH-1:0] shifted;
  logic [BIT_WIDTH-1:0]        field_mask;
  logic [BIT_WIDTH-1:0]        field;
  logic [CW-1:0]               field_w;
  logic                        pop;
  logic                        accept;
  logic [2*BIT_WIDTH-1:0]      popped_buf;
  logic [CW-1:0]               popped_cnt;
  logic [2*BIT_WIDTH-1:0]      next_buf;
  logic [CW-1:0]               next_cnt;

  // Mask built by shifting ones down so n = BIT_WIDTH-1 never overflows.
  always_comb begin
    shifted    = $signed(i_data) >>> cfg_off;
    field_mask = {BIT_WIDTH{1'b1}} >> (N_MAX - cfg_n);
    field      = shifted & field_mask;
    field_w    = CW'(cfg_n) + CW'(1);
  end

  always_comb begin
    o_valid = 1'b0;
    o_ready = 1'b0;
    o_last  = 1'b0;
    o_data  = pack_buf[BIT_WIDTH-1:0];
    case (state)
      RUN: begin
        o_valid = (cnt >= WORD_BITS);
        o_ready = (cnt < WORD_BITS) || (o_valid && i_ready);
      end
      FLUSH: begin
        o_valid = (cnt != '0);
        o_last  = o_valid && (cnt <= WORD_BITS);
      end
      default: ;
    endcase
  end

  // A same-cycle pop is applied first so the new field lands at the post-pop count.
  always_comb begin
    pop        = o_valid && i_ready;
    accept     = i_valid && o_ready;
    popped_buf = pop ? (pack_buf >> BIT_WIDTH) : pack_buf;
    popped_cnt = pop ? (cnt - WORD_BITS) : cnt;
    next_buf   = popped_buf;
    next_cnt   = popped_cnt;
    if (accept) begin
      next_buf = popped_buf | ({{BIT_WIDTH{1'b0}}, field} << popped_cnt);
      next_cnt = popped_cnt + field_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pack_buf <= '0;
      cnt      <= '0;
      cfg_n    <= '0;
      cfg_off  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cfg_load) begin
            cfg_n    <= i_n;
            cfg_off  <= i_offset;
            pack_buf <= '0;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          pack_buf <= next_buf;
          cnt      <= next_cnt;
          if (accept && i_last) state <= FLUSH;
        end
        FLUSH: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else if (pop) begin
            if (o_last) begin
              pack_buf <= '0;
              cnt      <= '0;
              state    <= IDLE;
            end else begin
              pack_buf <= next_buf;
              cnt      <= next_cnt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proteus_packer.sv
// tb/tb_proteus_packer.sv - directed self-checking bench for proteus_packer
module tb_proteus_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cfg_load;
  logic [3:0]  i_n;
  logic [3:0]  i_offset;
  logic        i_valid;
  logic [15:0] i_data;
  logic        i_last;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_data;
  logic        o_last;
  logic        i_ready;

  int checks = 0;
  int errors = 0;
  logic [16:0] words[$];

  proteus_packer #(.BIT_WIDTH(16), .BIT_IDX(4)) dut (
    .clk(clk), .rst(rst), .i_cfg_load(i_cfg_load), .i_n(i_n), .i_offset(i_offset),
    .i_valid(i_valid), .i_data(i_data), .i_last(i_last), .o_ready(o_ready),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  // Inputs only change just after posedge, so a negedge snapshot predicts the next transfer.
  always @(negedge clk)
    if (!rst && o_valid && i_ready) words.push_back({o_last, o_data});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_cfg(input logic [3:0] n, input logic [3:0] off);
    i_cfg_load = 1'b1; i_n = n; i_offset = off;
    @(posedge clk); #1;
    i_cfg_load = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int t = 0;
    i_valid = 1'b1; i_data = d; i_last = l;
    @(negedge clk);
    while (!o_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("send_timeout", 32'(t < 200), 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [15:0] d, input logic l);
    int t = 0;
    while (words.size() == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_present"}, 32'(words.size() != 0), 32'd1);
    if (words.size() != 0) begin
      logic [16:0] w;
      w = words.pop_front();
      check({tag, "_data"}, 32'(w[15:0]), 32'(d));
      check({tag, "_last"}, 32'(w[16]), 32'(l));
    end
  endtask

  task automatic expect_idle(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_extra_words"}, 32'(words.size()), 32'd0);
    check({tag, "_idle"}, {30'd0, o_valid, o_ready}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; i_cfg_load = 1'b0; i_n = '0; i_offset = '0;
    i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {o_valid, o_ready, o_last, o_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic pack
    i_ready = 1'b1;
    load_cfg(4'd7, 4'd0);
    send_beat(16'h0012, 1'b0);
    send_beat(16'h0034, 1'b1);
    expect_word("basic", 16'h3412, 1'b1);
    expect_idle("basic");

    // Shift with sign fill, partial flush
    load_cfg(4'd4, 4'd2);
    for (int k = 0; k < 4; k++) send_beat(16'hFFFC, k == 3);
    expect_word("sign0", 16'hFFFF, 1'b0);
    expect_word("sign1", 16'h000F, 1'b1);
    expect_idle("sign");

    // Word straddle: 30 bits -> two words
    load_cfg(4'd9, 4'd0);
    send_beat(16'h03FF, 1'b0);
    send_beat(16'h0000, 1'b0);
    send_beat(16'h03FF, 1'b1);
    expect_word("strad0", 16'h03FF, 1'b0);
    expect_word("strad1", 16'h3FF0, 1'b1);
    expect_idle("strad");

    // Backpressure: two 8-bit fields fill a word, third beat stalls
    i_ready = 1'b0;
    load_cfg(4'd7, 4'd0);
    send_beat(16'h0011, 1'b0);
    send_beat(16'h0022, 1'b0);
    i_valid = 1'b1; i_data = 16'h0033; i_last = 1'b0;
    @(negedge clk);
    check("bp_ready_low", 32'(o_ready), 32'd0);
    check("bp_valid", 32'(o_valid), 32'd1);
    for (int c = 0; c < 10; c++) begin
      check("bp_hold_data", 32'(o_data), 32'h2211);
      @(negedge clk);
    end
    check("bp_no_pop", 32'(words.size()), 32'd0);
    @(posedge clk); #1;
    i_ready = 1'b1;
    send_beat(16'h0033, 1'b0);
    send_beat(16'h0044, 1'b0);
    send_beat(16'h0055, 1'b1);
    expect_word("bp0", 16'h2211, 1'b0);
    expect_word("bp1", 16'h4433, 1'b0);
    expect_word("bp2", 16'h0055, 1'b1);
    expect_idle("bp");

    // Full-width streaming
    load_cfg(4'd15, 4'd0);
    for (int k = 1; k <= 8; k++) begin
      i_valid = 1'b1; i_data = 16'(k); i_last = (k == 8);
      @(negedge clk);
      check("stream_ready", 32'(o_ready), 32'd1);
      if (k > 1) check("stream_word", {o_valid, o_last, o_data}, {16'd0, 1'b1, 1'b0, 16'(k - 1)});
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_last = 1'b0;
    @(negedge clk);
    check("stream_final", {o_valid, o_last, o_data}, {16'd0, 1'b1, 1'b1, 16'h0008});
    @(posedge clk); #1;
    words.delete();
    expect_idle("stream");

    // Reset mid-stream with eight bits buffered
    i_ready = 1'b0;
    load_cfg(4'd7, 4'd0);
    send_beat(16'h0012, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_outputs", {o_valid, o_ready, o_last, o_data}, 32'd0);
    i_ready = 1'b1;
    i_valid = 1'b1; i_data = 16'h00EE; i_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rst_ignore", {30'd0, o_valid, o_ready}, 32'd0);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_last = 1'b0;
    check("rst_no_words", 32'(words.size()), 32'd0);
    load_cfg(4'd7, 4'd0);
    send_beat(16'h00AB, 1'b0);
    send_beat(16'h00CD, 1'b1);
    expect_word("post_rst", 16'hCDAB, 1'b1);
    expect_idle("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
